issue_stage: RTL
================

# issue_stage

Single-entry in-order issue stage between the instruction decoder and the execute stage. Drives register-file read addresses from the decoded instruction, holds the instruction while any source operand is reserved or its destination still has a write in flight, then latches operands into the execute pipeline register. On issue it reserves the destination in the register file and tracks pending writes locally to block write-after-write hazards.

## Interface
- STALL_CNT_W, 16: width of the saturating stall counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dec_valid_i / dec_ready_o  in/out  1  decoder handshake; transfer when both high.
- dec_rs1_i, dec_rs2_i, dec_rd_i  in  5  source and destination register numbers.
- dec_rs1v_i, dec_rs2v_i, dec_rdv_i  in  1  field-valid flags.
- dec_op_i  in  8  opaque operation code, passed through.
- dec_imm_i, dec_pc_i  in  32  immediate and PC, passed through.
- rf_r0_o, rf_r1_o  out  5  read addresses (= dec_rs1_i, dec_rs2_i, combinational).
- rf_r0v_o, rf_r1v_o  out  1  read-valid (= dec_valid_i & dec_rs1v_i / dec_rs2v_i).
- rf_opr0_i, rf_opr1_i  in  32  read data.
- rf_reserved_i  in  1  a valid source register is reserved.
- rf_rd_o  out  5  destination to reserve (= dec_rd_i).
- rf_reserve_o  out  1  reserve strobe; one cycle per qualifying issue.
- wb_i, wb_r_i  in  1, 5  writeback snoop, same signals that drive the register file.
- ex_valid_o / ex_ready_i  out/in  1  execute handshake.
- ex_op_o 8, ex_opr0_o 32, ex_opr1_o 32, ex_imm_o 32, ex_pc_o 32, ex_rd_o 5, ex_rdv_o 1  out  execute pipeline register.
- stall_cnt_o  out  STALL_CNT_W  saturating count of stalled cycles.

## Operation
- pend: local 32-bit pending-write bitmap; bit 0 is always 0.
- qual_rd = dec_rdv_i & (dec_rd_i != 0). Writes to x0 are never reserved or tracked.
- hazard = rf_reserved_i | (qual_rd & pend[dec_rd_i]).
- space = !ex_valid_o | ex_ready_i.
- dec_ready_o = !hazard & space (combinational; may depend on dec_valid_i via rf_reserved_i).
- issue = dec_valid_i & dec_ready_o.
- rf_reserve_o = issue & qual_rd (combinational; register file samples on the same edge).
- On issue: load ex_* from dec_* and rf_opr*_i; an invalid source stores rf data as supplied (0xFFFFFFFF); ex_valid_o <= 1; if qual_rd, pend[dec_rd_i] <= 1.
- No issue and ex_ready_i: ex_valid_o <= 0; data registers keep their values.
- No issue and !ex_ready_i: all ex_* hold.
- wb_i & wb_r_i != 0: pend[wb_r_i] <= 0. A simultaneous set and clear of the same bit cannot occur (the WAW check stalls); if both occur on different bits, both apply.
- stall_cnt_o increments when dec_valid_i & !dec_ready_o and saturates at all-ones.
- No flush: an issued instruction always completes and writes back if ex_rdv_o is set.

## Timing
- Reset: ex_valid_o=0, all ex_* data=0, pend=0, stall_cnt_o=0; dec_ready_o=1 after reset (no hazard, empty).
- Issue latency 1: transfer at edge N, ex_valid_o high from N.
- Reset asserted mid-operation clears everything immediately. Reservations held in the register file are cleared by the same rst.
- RAW: the consumer stalls while the source is reserved. Writeback at edge M clears both the reservation and pend, and the consumer issues in the cycle after M with the written data. No bypass path.
- Back-to-back independent instructions issue every cycle when ex_ready_i=1.

## Test plan
- Reset: hold rst with dec_valid_i=1 -> ex_valid_o=0, stall_cnt_o=0, rf_reserve_o=0. After release -> dec_ready_o=1.
- Independent issue: x1=10, x2=20, rs1=1, rs2=2, rd=3 -> next cycle ex_valid_o=1, opr0=10, opr1=20, ex_rd_o=3. rf_reserve_o high for 1 cycle with rf_rd_o=3.
- RAW: A rd=3 issued, then B rs1=3. Writeback wb_r_i=3 with result 30 occurs 4 cycles later -> B stalls 4 cycles, then issues with ex_opr0_o=30; stall_cnt_o=4.
- WAW: A rd=4 pending, then B with no sources and rd=4 -> dec_ready_o=0 until the cycle after wb of 4. B then reserves 4 and pend[4]=1.
- x0 destination: rd=0, rdv=1 -> rf_reserve_o=0. A following reader of x0 issues without stall and gets opr=0.
- Backpressure: ex_valid_o=1, ex_ready_i=0 for 3 cycles -> dec_ready_o=0 and ex_* stable. Then ex_ready_i=1 with a new valid instruction -> replaced in the same edge, ex_valid_o stays 1.
- Counter saturation: with STALL_CNT_W=4, stall 20 cycles -> stall_cnt_o=15.

Source files
------------

// File: rtl/issue_stage.sv
// issue_stage: single-entry in-order issue stage. Reads operands through the
// register-file read ports, holds the decoded instruction while a source is
// reserved or its destination still has a write in flight, and latches the
// instruction plus operands into the execute pipeline register.
module issue_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  // decoder handshake and fields
  input  logic                   dec_valid_i,
  output logic                   dec_ready_o,
  input  logic [4:0]             dec_rs1_i,
  input  logic [4:0]             dec_rs2_i,
  input  logic [4:0]             dec_rd_i,
  input  logic                   dec_rs1v_i,
  input  logic                   dec_rs2v_i,
  input  logic                   dec_rdv_i,
  input  logic [7:0]             dec_op_i,
  input  logic [31:0]            dec_imm_i,
  input  logic [31:0]            dec_pc_i,
  // register-file read / reserve
  output logic [4:0]             rf_r0_o,
  output logic [4:0]             rf_r1_o,
  output logic                   rf_r0v_o,
  output logic                   rf_r1v_o,
  input  logic [31:0]            rf_opr0_i,
  input  logic [31:0]            rf_opr1_i,
  input  logic                   rf_reserved_i,
  output logic [4:0]             rf_rd_o,
  output logic                   rf_reserve_o,
  // writeback snoop
  input  logic                   wb_i,
  input  logic [4:0]             wb_r_i,
  // execute pipeline register
  output logic                   ex_valid_o,
  input  logic                   ex_ready_i,
  output logic [7:0]             ex_op_o,
  output logic [31:0]            ex_opr0_o,
  output logic [31:0]            ex_opr1_o,
  output logic [31:0]            ex_imm_o,
  output logic [31:0]            ex_pc_o,
  output logic [4:0]             ex_rd_o,
  output logic                   ex_rdv_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  logic                   ex_valid_q, ex_valid_d;
  logic [7:0]             ex_op_q, ex_op_d;
  logic [31:0]            ex_opr0_q, ex_opr0_d;
  logic [31:0]            ex_opr1_q, ex_opr1_d;
  logic [31:0]            ex_imm_q, ex_imm_d;
  logic [31:0]            ex_pc_q, ex_pc_d;
  logic [4:0]             ex_rd_q, ex_rd_d;
  logic                   ex_rdv_q, ex_rdv_d;
  logic [31:0]            pend_q, pend_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic qual_rd_s;
  logic hazard_s;
  logic space_s;
  logic issue_s;

  // Read ports follow the decoder fields directly so data arrives in the same cycle.
  assign rf_r0_o  = dec_rs1_i;
  assign rf_r1_o  = dec_rs2_i;
  assign rf_r0v_o = dec_valid_i & dec_rs1v_i;
  assign rf_r1v_o = dec_valid_i & dec_rs2v_i;
  assign rf_rd_o  = dec_rd_i;

  // Hazard detection and decoder handshake; x0 destinations are never tracked.
  always_comb begin
    qual_rd_s    = dec_rdv_i & (dec_rd_i != 5'd0);
    hazard_s     = rf_reserved_i | (qual_rd_s & pend_q[dec_rd_i]);
    space_s      = ~ex_valid_q | ex_ready_i;
    dec_ready_o  = ~rst & ~hazard_s & space_s;
    issue_s      = dec_valid_i & dec_ready_o;
    rf_reserve_o = issue_s & qual_rd_s;
  end

  // Next state of the execute register, pending-write bitmap and stall counter.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_op_d     = ex_op_q;
    ex_opr0_d   = ex_opr0_q;
    ex_opr1_d   = ex_opr1_q;
    ex_imm_d    = ex_imm_q;
    ex_pc_d     = ex_pc_q;
    ex_rd_d     = ex_rd_q;
    ex_rdv_d    = ex_rdv_q;
    pend_d      = pend_q;
    stall_cnt_d = stall_cnt_q;

    if (issue_s) begin
      ex_valid_d = 1'b1;
      ex_op_d    = dec_op_i;
      ex_opr0_d  = rf_opr0_i;
      ex_opr1_d  = rf_opr1_i;
      ex_imm_d   = dec_imm_i;
      ex_pc_d    = dec_pc_i;
      ex_rd_d    = dec_rd_i;
      ex_rdv_d   = dec_rdv_i;
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end

    // Clear on writeback first; a set on the same bit cannot coincide because
    // the WAW check stalls that issue.
    if (wb_i && (wb_r_i != 5'd0)) begin
      pend_d[wb_r_i] = 1'b0;
    end else begin
      pend_d = pend_d;
    end
    if (issue_s && qual_rd_s) begin
      pend_d[dec_rd_i] = 1'b1;
    end else begin
      pend_d = pend_d;
    end
    pend_d[0] = 1'b0;

    if (dec_valid_i && !dec_ready_o && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_op_q     <= 8'd0;
      ex_opr0_q   <= 32'd0;
      ex_opr1_q   <= 32'd0;
      ex_imm_q    <= 32'd0;
      ex_pc_q     <= 32'd0;
      ex_rd_q     <= 5'd0;
      ex_rdv_q    <= 1'b0;
      pend_q      <= 32'd0;
      stall_cnt_q <= {STALL_CNT_W{1'b0}};
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_opr0_q   <= ex_opr0_d;
      ex_opr1_q   <= ex_opr1_d;
      ex_imm_q    <= ex_imm_d;
      ex_pc_q     <= ex_pc_d;
      ex_rd_q     <= ex_rd_d;
      ex_rdv_q    <= ex_rdv_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o  = ex_valid_q;
  assign ex_op_o     = ex_op_q;
  assign ex_opr0_o   = ex_opr0_q;
  assign ex_opr1_o   = ex_opr1_q;
  assign ex_imm_o    = ex_imm_q;
  assign ex_pc_o     = ex_pc_q;
  assign ex_rd_o     = ex_rd_q;
  assign ex_rdv_o    = ex_rdv_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
